mux8_word_serializer: RTL and testbench

//   Parallel-to-serial front end for the 8:1 data selector stage. Accepts one

---
 rtl/mux8_word_serializer.sv | 103 ++++++++++
 tb/tb_mux8_word_serializer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_word_serializer.sv
// Purpose : parallel-to-serial front end for an 8:1 selector; holds one word, steps sel per beat.
// Latency : word accepted at edge N -> first bit valid in the cycle after edge N; WIDTH beats/word.
// Backpr. : out_ready=0 freezes hold/sel/state; in_ready=1 only when IDLE or on a consumed last beat.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    word handshake; in_data is the WIDTH-bit word
//   mux_d, mux_sel       held word and current bit index, registered (glitch-free selector inputs)
//   out_valid/out_ready  bit handshake; out_bit = mux_d[mux_sel], out_last on the final index
//   busy                 a word is being serialized
module mux8_word_serializer #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] mux_d,
    output logic [SEL_W-1:0] mux_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
    localparam logic [SEL_W-1:0] SEL_FINAL = MSB_FIRST ? '0 : SEL_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hold_q,  hold_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic               at_end;

    assign at_end = (sel_q == SEL_FINAL);

    // Ready depends only on state, sel and out_ready so there is no
    // combinational loop back through the upstream valid.
    assign in_ready = (state_q == IDLE) || (out_ready && at_end);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    sel_d   = SEL_FIRST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    if (!at_end) begin
                        sel_d = MSB_FIRST ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
                    end else if (in_valid) begin
                        // Back-to-back load: no bubble between words.
                        hold_d = in_data;
                        sel_d  = SEL_FIRST;
                    end else begin
                        // Word finished; hold is kept so mux_d stays put.
                        state_d = IDLE;
                        sel_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
        end
    end

    // All outputs besides in_ready decode straight from the registers.
    assign busy      = (state_q == SHIFT);
    assign out_valid = busy;
    assign out_last  = busy && at_end;
    assign mux_d     = hold_q;
    assign mux_sel   = sel_q;
    assign out_bit   = hold_q[sel_q];

endmodule

// File: tb/tb_mux8_word_serializer.sv
// Purpose : self-checking bench for mux8_word_serializer, LSB-first and MSB-first instances side by side.
// Latency : model tracks beat index per word; outputs compared every negedge.
// Backpr. : out_ready patterns include stalls on middle and last beats.
module tb_mux8_word_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;

    logic         rdy_l, vld_l, bit_l, last_l, busy_l;
    logic [W-1:0] d_l;
    logic [2:0]   sel_l;
    logic         rdy_m, vld_m, bit_m, last_m, busy_m;
    logic [W-1:0] d_m;
    logic [2:0]   sel_m;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mux8_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data),
        .mux_d(d_l), .mux_sel(sel_l), .out_valid(vld_l), .out_ready(out_ready),
        .out_bit(bit_l), .out_last(last_l), .busy(busy_l));

    mux8_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data),
        .mux_d(d_m), .mux_sel(sel_m), .out_valid(vld_m), .out_ready(out_ready),
        .out_bit(bit_m), .out_last(last_m), .busy(busy_m));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word in flight plus the index k of the beat being offered.
    // LSB instance offers bit k, MSB instance offers bit W-1-k.
    bit         m_busy;
    logic [W-1:0] m_word;
    int         m_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_word <= '0;
            m_k    <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_word <= in_data;
                m_k    <= 0;
            end
        end else if (out_ready) begin
            if (m_k == W - 1) begin
                if (in_valid) begin
                    m_word <= in_data;
                    m_k    <= 0;
                end else begin
                    m_busy <= 1'b0;
                end
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    int  e_sl, e_sm;
    bit  e_rdy, e_last;

    always @(negedge clk) begin
        if (chk_en) begin
            e_sl   = m_busy ? m_k : 0;
            e_sm   = m_busy ? (W - 1 - m_k) : 0;
            e_rdy  = !m_busy || (out_ready && m_k == W - 1);
            e_last = m_busy && (m_k == W - 1);
            check("lsb in_ready", rdy_l, e_rdy);
            check("msb in_ready", rdy_m, e_rdy);
            check("lsb out_valid", vld_l, m_busy);
            check("msb out_valid", vld_m, m_busy);
            check("lsb busy", busy_l, m_busy);
            check("msb busy", busy_m, m_busy);
            check("lsb mux_d", d_l, m_word);
            check("msb mux_d", d_m, m_word);
            check("lsb mux_sel", sel_l, e_sl);
            check("msb mux_sel", sel_m, e_sm);
            check("lsb out_last", last_l, e_last);
            check("msb out_last", last_m, e_last);
            if (m_busy) begin
                check("lsb out_bit", bit_l, m_word[e_sl]);
                check("msb out_bit", bit_m, m_word[e_sm]);
            end
        end
    end

    // Present a word; returns after the accepting edge (+1) with in_valid dropped.
    task automatic send(input logic [W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_l && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain bound", (n < 100) ? 1 : 0, 1);
    endtask

    logic [7:0] exp_a5, exp_81, pat;

    initial begin
        exp_a5 = 8'b1010_0101;   // beat order bits: 1,0,1,0,0,1,0,1
        exp_81 = 8'b1000_0001;   // beat order bits: 1,0,0,0,0,0,0,1

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst out_valid", vld_l, 0);
        check("rst busy", busy_l, 0);
        check("rst mux_d", d_l, 8'h00);
        check("rst mux_sel", sel_l, 0);
        check("rst in_ready", rdy_l, 1);
        chk_en = 1'b1;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: 0xA5 LSB first, out_ready high
        out_ready = 1'b1;
        send(8'hA5);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            check("t1 out_bit", bit_l, exp_a5[7 - b]);
            check("t1 mux_sel", sel_l, b);
            check("t1 out_last", last_l, (b == 7) ? 1 : 0);
        end
        @(negedge clk);
        check("t1 busy after", busy_l, 0);

        // 2: 0x3C then 0xC3 back-to-back
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(posedge clk); #1;
        in_data  = 8'hC3;
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            check("t2 out_valid", vld_l, 1);
            check("t2 in_ready", rdy_l, (b == 7 || b == 15) ? 1 : 0);
            if (b == 8) begin
                check("t2 beat9 mux_d", d_l, 8'hC3);
                check("t2 beat9 mux_sel", sel_l, 0);
            end
            @(posedge clk); #1;
            if (b == 7) in_valid = 1'b0;
        end
        wait_idle();

        // 3: 0xF0 with a 3-cycle stall on beat 4
        @(posedge clk); #1;
        send(8'hF0);
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("t3 stall sel", sel_l, 3);
            check("t3 stall bit", bit_l, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t3 beat5 sel", sel_l, 4);
        check("t3 beat5 bit", bit_l, 1);
        wait_idle();

        // 4: async reset mid-word at sel=5
        @(posedge clk); #1;
        send(8'h5B);
        for (int b = 0; b < 5; b++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("t4 pre sel", sel_l, 5);
        #2 rst_n = 1'b0;
        #1;
        check("t4 async out_valid", vld_l, 0);
        check("t4 async mux_sel", sel_l, 0);
        check("t4 async msb mux_sel", sel_m, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        check("t4 post in_ready", rdy_l, 1);
        check("t4 post busy", busy_l, 0);

        // 5: 0x81 on the MSB-first instance
        @(posedge clk); #1;
        send(8'h81);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            check("t5 mux_sel", sel_m, 7 - b);
            check("t5 out_bit", bit_m, exp_81[7 - b]);
            check("t5 out_last", last_m, (b == 7) ? 1 : 0);
        end
        wait_idle();

        // 6: in_valid held while the last beat is stalled
        @(posedge clk); #1;
        send(8'h5A);
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int b = 0; b < 7; b++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            check("t6 stall in_ready", rdy_l, 0);
            check("t6 stall mux_d", d_l, 8'h5A);
            check("t6 stall sel", sel_l, 7);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t6 release in_ready", rdy_l, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t6 load mux_d", d_l, 8'h77);
        check("t6 load sel", sel_l, 0);

        // Extra: mixed stall pattern across two back-to-back words
        pat = 8'b1011_0110;
        in_valid = 1'b1;
        in_data  = 8'hE4;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            out_ready = pat[c % 8];
            in_data   = (c < 20) ? 8'h1D : 8'hB2;
            if (c == 30) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        wait_idle();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
